// File: rtl/adc_meas_seq.sv
`default_nettype none
// ============================================================================
//  Module   : adc_meas_seq
//  Purpose  : Measurement sequencer for the multislope ADC core. Walks a
//             4-entry slot table, drives mux/autozero selects, settles,
//             starts the core, and posts each result with a slot tag on a
//             valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_meas_seq #(
  parameter int CH_W    = 2,
  parameter int RUNUP_W = 11,
  parameter int SETTLE  = 200,
  parameter int TIMEOUT = 2000000
) (
  input  logic               mclk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         slot_last,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [CH_W-1:0]    cfg_mux,
  input  logic               cfg_az,
  input  logic [RUNUP_W-1:0] cfg_runup,
  output logic [CH_W-1:0]    mux_sel,
  output logic               az_sel,
  output logic               conv_start,
  output logic [RUNUP_W-1:0] conv_runup,
  input  logic               conv_done,
  input  logic [31:0]        conv_result,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic [2:0]         res_tag,
  output logic               busy,
  output logic               overrun,
  output logic               fault
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_CONV    = 3'd3;
  localparam logic [2:0] ST_ADVANCE = 3'd4;

  localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LAST  = SCNT_W'(SETTLE - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT - 1);

  logic [CH_W-1:0]    tbl_mux   [4];
  logic [3:0]         tbl_az;
  logic [RUNUP_W-1:0] tbl_runup [4];

  logic [2:0]         state, state_nxt;
  logic [1:0]         slot, slot_nxt;
  logic               phase, phase_nxt;
  logic [SCNT_W-1:0]  settle_cnt;
  logic [TCNT_W-1:0]  tmo_cnt;

  logic settle_done, tmo_hit, enter_settle, res_load, flag_clr;

  assign settle_done  = (settle_cnt == SETTLE_LAST);
  assign tmo_hit      = (tmo_cnt == TIMEOUT_LAST);
  assign enter_settle = (state_nxt == ST_SETTLE) && (state != ST_SETTLE);
  assign res_load     = (state == ST_CONV) && conv_done;
  assign flag_clr     = (state == ST_IDLE) && !enable;

  // State register
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; conv_done wins over a simultaneous timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (enable) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (settle_done) state_nxt = ST_START;
      ST_START:   state_nxt = ST_CONV;
      ST_CONV: begin
        if (conv_done)    state_nxt = ST_ADVANCE;
        else if (tmo_hit) state_nxt = ST_IDLE;
      end
      ST_ADVANCE: state_nxt = enable ? ST_SETTLE : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Next slot/phase: restart at slot 0 from IDLE, otherwise step through the
  // table; a slot above slot_last also wraps to 0
  always_comb begin
    slot_nxt  = slot;
    phase_nxt = phase;
    if (state == ST_IDLE) begin
      slot_nxt  = 2'd0;
      phase_nxt = tbl_az[0];
    end else if (state == ST_ADVANCE) begin
      if (phase) begin
        phase_nxt = 1'b0;
      end else begin
        slot_nxt  = (slot >= slot_last) ? 2'd0 : slot + 2'd1;
        phase_nxt = tbl_az[slot_nxt];
      end
    end
  end

  // Moore outputs
  always_comb begin
    conv_start = (state == ST_START);
    busy       = (state != ST_IDLE);
  end

  // Slot table, writable at any time
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        tbl_mux[i]   <= '0;
        tbl_runup[i] <= '0;
      end
      tbl_az <= '0;
    end else if (cfg_we) begin
      tbl_mux[cfg_addr]   <= cfg_mux;
      tbl_az[cfg_addr]    <= cfg_az;
      tbl_runup[cfg_addr] <= cfg_runup;
    end
  end

  // Conversion context, captured only on entry to SETTLE so later table
  // writes never disturb a conversion in flight
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= '0;
      phase      <= 1'b0;
      mux_sel    <= '0;
      az_sel     <= 1'b0;
      conv_runup <= '0;
    end else if (enter_settle) begin
      slot       <= slot_nxt;
      phase      <= phase_nxt;
      mux_sel    <= tbl_mux[slot_nxt];
      az_sel     <= phase_nxt;
      conv_runup <= (tbl_runup[slot_nxt] == '0) ? RUNUP_W'(1) : tbl_runup[slot_nxt];
    end
  end

  // Settle and timeout counters
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      if (enter_settle)            settle_cnt <= '0;
      else if (state == ST_SETTLE) settle_cnt <= settle_cnt + 1'b1;
      if (state == ST_START)       tmo_cnt <= '0;
      else if (state == ST_CONV)   tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Result register with sticky overrun/fault flags
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      overrun   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      if (res_load) begin
        res_valid <= 1'b1;
        res_data  <= conv_result;
        res_tag   <= {phase, slot};
        if (res_valid && !res_ready) overrun <= 1'b1;
      end else begin
        if (res_valid && res_ready) res_valid <= 1'b0;
        if (flag_clr)               overrun   <= 1'b0;
      end
      if ((state == ST_CONV) && !conv_done && tmo_hit) fault <= 1'b1;
      else if (flag_clr)                               fault <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_meas_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_meas_seq
//  Purpose  : Self-checking bench for adc_meas_seq with an ADC core model,
//             a slot-sequence reference model and a result-port model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_meas_seq;

  localparam int CH_W    = 2;
  localparam int RUNUP_W = 11;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 40;

  logic               mclk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic [1:0]         slot_last = 2'd0;
  logic               cfg_we = 1'b0;
  logic [1:0]         cfg_addr = 2'd0;
  logic [CH_W-1:0]    cfg_mux = '0;
  logic               cfg_az = 1'b0;
  logic [RUNUP_W-1:0] cfg_runup = '0;
  logic               conv_done = 1'b0;
  logic [31:0]        conv_result = '0;
  logic               res_ready = 1'b1;
  logic [CH_W-1:0]    mux_sel;
  logic               az_sel, conv_start, res_valid, busy, overrun, fault;
  logic [RUNUP_W-1:0] conv_runup;
  logic [31:0]        res_data;
  logic [2:0]         res_tag;

  adc_meas_seq #(.CH_W(CH_W), .RUNUP_W(RUNUP_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .mclk(mclk), .rst_n(rst_n), .enable(enable), .slot_last(slot_last),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mux(cfg_mux), .cfg_az(cfg_az),
    .cfg_runup(cfg_runup), .mux_sel(mux_sel), .az_sel(az_sel), .conv_start(conv_start),
    .conv_runup(conv_runup), .conv_done(conv_done), .conv_result(conv_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .busy(busy), .overrun(overrun), .fault(fault)
  );

  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Shadow copy of the slot table as written by the bench
  logic [CH_W-1:0]    sh_mux   [4];
  logic               sh_az    [4];
  logic [RUNUP_W-1:0] sh_runup [4];

  // ---------------- ADC core model ----------------
  bit          core_hang  = 0;
  bit          core_fixed = 0;
  int          core_cnt   = 0;
  initial begin : core
    forever begin
      @(posedge mclk); #1;
      conv_done = 1'b0;
      if (!rst_n) core_cnt = 0;
      else begin
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            conv_done   = 1'b1;
            conv_result = core_fixed ? 32'h00C8_1234 : $urandom;
          end
        end
        if (conv_start && !core_hang) core_cnt = $urandom_range(1, 8);
      end
    end
  end

  // ---------------- Reference model / monitor ----------------
  logic [2:0]  seq_q[$];
  logic [2:0]  exp_tags[$];
  int          seq_idx = 0;
  int          cyc = 0;
  int          last_done_cyc = 0;
  bit          gap_armed = 0;
  logic        m_valid = 0, m_ovr = 0;
  logic [31:0] m_data = 0;
  logic [2:0]  m_tag = 0;
  logic        p_ok = 0, p_done = 0, p_ready = 0, p_busy = 0, p_en = 0;
  logic [31:0] p_data = 0;
  logic [2:0]  p_tag = 0;
  logic [2:0]  t_cur;
  logic [RUNUP_W-1:0] t_run;

  // Conversion order implied by the table: each active slot, its autozero
  // conversion first when enabled
  function automatic void build_seq();
    seq_q.delete();
    for (int s = 0; s <= int'(slot_last); s++) begin
      if (sh_az[s]) seq_q.push_back({1'b1, 2'(s)});
      seq_q.push_back({1'b0, 2'(s)});
    end
  endfunction

  initial begin : mon
    forever begin
      @(negedge mclk);
      cyc++;
      if (!rst_n) begin
        m_valid = 0; m_data = 0; m_tag = 0; m_ovr = 0; p_ok = 0;
        seq_idx = 0; exp_tags.delete(); gap_armed = 0;
      end else begin
        if (p_ok) begin
          if (p_done) begin
            if (m_valid && !p_ready) m_ovr = 1;
            m_valid = 1; m_data = p_data; m_tag = p_tag;
          end else if (m_valid && p_ready) m_valid = 0;
          if (!p_busy && !p_en) m_ovr = 0;
        end
        chk("res_valid", res_valid, m_valid);
        chk("res_data", res_data, m_data);
        chk("res_tag", res_tag, m_tag);
        chk("overrun", overrun, m_ovr);
        if (!busy) begin
          seq_idx = 0; exp_tags.delete(); gap_armed = 0;
        end
        if (conv_start) begin
          build_seq();
          if (seq_idx >= seq_q.size()) seq_idx = 0;
          t_cur = seq_q[seq_idx];
          seq_idx = (seq_idx + 1) % seq_q.size();
          t_run = (sh_runup[t_cur[1:0]] == 0) ? RUNUP_W'(1) : sh_runup[t_cur[1:0]];
          chk("mux_sel", mux_sel, sh_mux[t_cur[1:0]]);
          chk("az_sel", az_sel, t_cur[2]);
          chk("conv_runup", conv_runup, t_run);
          if (gap_armed) chk("conv_gap", cyc - last_done_cyc, SETTLE + 2);
          exp_tags.push_back(t_cur);
        end
        p_tag = 0;
        if (conv_done) begin
          chk("pending_conv", exp_tags.size(), 1);
          if (exp_tags.size() > 0) p_tag = exp_tags.pop_front();
          gap_armed = 1; last_done_cyc = cyc;
        end
        p_ok = 1; p_done = conv_done; p_data = conv_result;
        p_ready = res_ready; p_busy = busy; p_en = enable;
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge mclk); #2;
  endtask

  task automatic cfg_write(input int a, input int mux, input bit az, input int runup);
    cfg_we = 1; cfg_addr = 2'(a); cfg_mux = CH_W'(mux); cfg_az = az; cfg_runup = RUNUP_W'(runup);
    tick();
    cfg_we = 0;
    sh_mux[a] = CH_W'(mux); sh_az[a] = az; sh_runup[a] = RUNUP_W'(runup);
  endtask

  task automatic wait_start(input int max, output int n);
    n = 0;
    while (!conv_start && n < max) begin tick(); n++; end
    chk("conv_start_seen", conv_start, 1);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!conv_done && n < max) begin tick(); n++; end
    chk("conv_done_seen", conv_done, 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin tick(); n++; end
    chk("went_idle", busy, 0);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_mux_sel"}, mux_sel, 0);
    chk({pfx, "_az_sel"}, az_sel, 0);
    chk({pfx, "_conv_start"}, conv_start, 0);
    chk({pfx, "_conv_runup"}, conv_runup, 0);
    chk({pfx, "_res_valid"}, res_valid, 0);
    chk({pfx, "_res_data"}, res_data, 0);
    chk({pfx, "_res_tag"}, res_tag, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_overrun"}, overrun, 0);
    chk({pfx, "_fault"}, fault, 0);
  endtask

  // ---------------- Main sequence ----------------
  int          n;
  int          starts;
  logic [31:0] held;
  logic [2:0]  exp_seq [5];

  initial begin : main
    for (int i = 0; i < 4; i++) begin sh_mux[i] = 0; sh_az[i] = 0; sh_runup[i] = 0; end
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1;
    tick();

    // Single slot, fixed core result, continuous repetition
    cfg_write(0, 1, 0, 200);
    slot_last = 0; res_ready = 1; core_fixed = 1;
    enable = 1;
    wait_start(SETTLE + 10, n);
    chk("t1_start_latency", n, SETTLE + 1);
    chk("t1_runup", conv_runup, 200);
    for (int k = 0; k < 3; k++) begin
      wait_done(50); tick();
      chk("t1_valid", res_valid, 1);
      chk("t1_data", res_data, 32'h00C8_1234);
      chk("t1_tag", res_tag, 0);
    end
    enable = 0; core_fixed = 0;
    wait_idle(100);

    // Three slots, autozero on slot 1
    cfg_write(0, 2, 0, 10);
    cfg_write(1, 3, 1, 0);
    cfg_write(2, 1, 0, 77);
    slot_last = 2;
    exp_seq[0] = 3'd0; exp_seq[1] = 3'd5; exp_seq[2] = 3'd1; exp_seq[3] = 3'd2; exp_seq[4] = 3'd0;
    enable = 1;
    for (int k = 0; k < 5; k++) begin
      wait_done(100); tick();
      chk("t2_tag_seq", res_tag, exp_seq[k]);
    end
    enable = 0;
    wait_idle(100);

    // Overrun: two results without a reader
    res_ready = 0;
    enable = 1;
    wait_done(100); tick();
    chk("t3_valid", res_valid, 1);
    chk("t3_no_ovr_yet", overrun, 0);
    wait_done(100); tick();
    chk("t3_overrun", overrun, 1);
    res_ready = 1; tick();
    chk("t3_overrun_sticky", overrun, 1);
    enable = 0;
    wait_idle(100);
    tick();
    chk("t3_overrun_cleared", overrun, 0);

    // enable dropped during CONV
    res_ready = 0;
    enable = 1;
    wait_start(100, n);
    tick();
    enable = 0;
    wait_done(50);
    held = conv_result;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("t4_busy_fall", n, 2);
    chk("t4_valid", res_valid, 1);
    chk("t4_data", res_data, held);
    starts = 0;
    repeat (30) begin tick(); if (conv_start) starts++; end
    chk("t4_no_restart", starts, 0);

    // Timeout: core never answers; pending result must survive
    core_hang = 1;
    enable = 1;
    wait_start(100, n);
    enable = 0;
    n = 0;
    while (!fault && n < TIMEOUT + 20) begin tick(); n++; end
    chk("t5_fault_latency_ok", (n >= TIMEOUT && n <= TIMEOUT + 2), 1);
    chk("t5_fault", fault, 1);
    chk("t5_idle", busy, 0);
    chk("t5_valid_kept", res_valid, 1);
    chk("t5_data_kept", res_data, held);
    tick();
    chk("t5_fault_cleared", fault, 0);
    core_hang = 0; res_ready = 1;
    repeat (2) tick();

    // Reset pulsed during SETTLE
    enable = 1;
    tick(); tick();
    chk("t6_in_settle", busy, 1);
    rst_n = 0; enable = 0;
    #1;
    check_reset_vals("t6_async");
    for (int i = 0; i < 4; i++) begin sh_mux[i] = 0; sh_az[i] = 0; sh_runup[i] = 0; end
    tick();
    rst_n = 1;
    starts = 0;
    repeat (20) begin tick(); if (conv_start) starts++; end
    chk("t6_no_start", starts, 0);
    enable = 1;
    wait_start(SETTLE + 10, n);
    chk("t6_restart_latency", n, SETTLE + 1);
    chk("t6_runup_min", conv_runup, 1);
    enable = 0;
    wait_idle(100);
    slot_last = 0;

    // Randomized tables, slot counts and reader back-pressure
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 4; a++)
        cfg_write(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2047));
      slot_last = 2'($urandom_range(0, 3));
      enable = 1;
      repeat ($urandom_range(200, 400)) begin
        res_ready = ($urandom_range(0, 2) != 0);
        tick();
      end
      enable = 0;
      wait_idle(200);
      res_ready = 1;
      repeat (3) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
